// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem, latches the instruction and
// advances the PC from branch/jump/halt decisions and the dmem handshake.
module fetch_unit #(
  parameter int WORD_W = 32,
  parameter logic [WORD_W-1:0] PC_INIT = {WORD_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  output logic [WORD_W-1:0] imemload,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  input  logic              branch,
  input  logic              jal,
  input  logic              jalr,
  input  logic              halt,
  input  logic [WORD_W-1:0] br_target,
  input  logic [WORD_W-1:0] jalr_target,
  input  logic              dmem_req,
  input  logic              dhit,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [WORD_W-1:0] PC_STEP = {{(WORD_W-3){1'b0}}, 3'b100};

  state_t            state_r;
  state_t            state_n_s;
  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] imemload_r;
  logic              instr_valid_r;
  logic [WORD_W-1:0] next_pc_s;
  logic [WORD_W-1:0] pc_plus4_s;
  logic              advance_s;
  logic              latch_s;

  // Instruction addresses are word aligned; JALR's bit-0 clear is subsumed here.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

  // Next-PC selection: jalr beats branch/jal, which beat sequential.
  always_comb begin
    pc_plus4_s = pc_r + PC_STEP;
    next_pc_s  = pc_plus4_s;
    if (jalr) begin
      next_pc_s = align_word(jalr_target);
    end else if (branch || jal) begin
      next_pc_s = align_word(br_target);
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // FSM next-state and PC-advance decode.
  always_comb begin
    state_n_s = state_r;
    advance_s = 1'b0;
    latch_s   = 1'b0;
    case (state_r)
      FETCH: begin
        if (ihit) begin
          latch_s   = 1'b1;
          state_n_s = EXEC;
        end else begin
          state_n_s = FETCH;
        end
      end
      EXEC: begin
        if (halt) begin
          state_n_s = HALTED;
        end else if (dmem_req && !dhit) begin
          state_n_s = MEM_WAIT;
        end else begin
          advance_s = 1'b1;
          state_n_s = FETCH;
        end
      end
      MEM_WAIT: begin
        if (dhit) begin
          advance_s = 1'b1;
          state_n_s = FETCH;
        end else begin
          state_n_s = MEM_WAIT;
        end
      end
      HALTED: begin
        state_n_s = HALTED;
      end
      default: begin
        state_n_s = FETCH;
      end
    endcase
  end

  // State, PC and instruction latch registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r       <= FETCH;
      pc_r          <= PC_INIT;
      imemload_r    <= {WORD_W{1'b0}};
      instr_valid_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      if (advance_s) begin
        pc_r          <= next_pc_s;
        instr_valid_r <= 1'b0;
      end else if (latch_s) begin
        imemload_r    <= imem_rdata;
        instr_valid_r <= 1'b1;
      end else if (state_n_s == HALTED) begin
        instr_valid_r <= 1'b0;
      end else begin
        instr_valid_r <= instr_valid_r;
      end
    end
  end

  assign iREN        = nRST && (state_r == FETCH);
  assign halted      = (state_r == HALTED);
  assign imemaddr    = pc_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign imemload    = imemload_r;
  assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected values are hand-computed per step.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imem_rdata;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch, jal, jalr, halt;
  logic [31:0] br_target, jalr_target;
  logic        dmem_req, dhit;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imem_rdata(imem_rdata), .iREN(iREN),
    .imemaddr(imemaddr), .imemload(imemload), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .branch(branch), .jal(jal), .jalr(jalr), .halt(halt),
    .br_target(br_target), .jalr_target(jalr_target), .dmem_req(dmem_req),
    .dhit(dhit), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; imem_rdata = 32'h0;
    branch = 1'b0; jal = 1'b0; jalr = 1'b0; halt = 1'b0;
    br_target = 32'h0; jalr_target = 32'h0; dmem_req = 1'b0; dhit = 1'b0;
    step(); step();
    check("rst_pc", pc, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_iren", {31'b0, iREN}, 32'h0);
    nRST = 1'b1; #1;
    check("fetch_iren", {31'b0, iREN}, 32'h1);

    // T1: sequential ADDI stream, two cycles per instruction
    ihit = 1'b1; imem_rdata = 32'h0010_0093;
    step();
    check("t1_exec_valid", {31'b0, instr_valid}, 32'h1);
    check("t1_exec_load", imemload, 32'h0010_0093);
    check("t1_exec_iren", {31'b0, iREN}, 32'h0);
    check("t1_exec_p4", pc_plus4, 32'h4);
    imem_rdata = 32'h0020_0113;
    step();
    check("t1_addr4", imemaddr, 32'h4);
    check("t1_fetch_valid", {31'b0, instr_valid}, 32'h0);
    check("t1_fetch_iren", {31'b0, iREN}, 32'h1);
    step();
    check("t1_exec2_load", imemload, 32'h0020_0113);
    step();
    check("t1_addr8", imemaddr, 32'h8);
    step(); step();
    check("t1_addrC", imemaddr, 32'hC);

    // T2: branch target low bits dropped
    step();
    branch = 1'b1; br_target = 32'h0000_0102;
    step();
    branch = 1'b0;
    check("t2_addr", imemaddr, 32'h0000_0100);

    // T3: jalr beats branch
    step();
    check("t3_p4", pc_plus4, 32'h0000_0104);
    jalr = 1'b1; branch = 1'b1; jalr_target = 32'h0000_0041; br_target = 32'h0000_0200;
    step();
    jalr = 1'b0; branch = 1'b0;
    check("t3_pc", pc, 32'h0000_0040);

    // T4: load with three MEM_WAIT cycles, then a zero-wait dmem access
    step();
    dmem_req = 1'b1; dhit = 1'b0;
    step();
    check("t4_mw1_pc", pc, 32'h40);
    check("t4_mw1_valid", {31'b0, instr_valid}, 32'h1);
    check("t4_mw1_iren", {31'b0, iREN}, 32'h0);
    step();
    check("t4_mw2_pc", pc, 32'h40);
    step();
    check("t4_mw3_pc", pc, 32'h40);
    check("t4_mw3_iren", {31'b0, iREN}, 32'h0);
    dhit = 1'b1;
    step();
    dmem_req = 1'b0; dhit = 1'b0;
    check("t4_after_pc", pc, 32'h44);
    check("t4_after_iren", {31'b0, iREN}, 32'h1);
    step();
    dmem_req = 1'b1; dhit = 1'b1;
    step();
    dmem_req = 1'b0; dhit = 1'b0;
    check("t4_nowait_pc", pc, 32'h48);
    check("t4_nowait_iren", {31'b0, iREN}, 32'h1);

    // T5: halt wins, stays halted until reset
    step();
    halt = 1'b1; dmem_req = 1'b1; branch = 1'b1; br_target = 32'h0000_0300;
    step();
    halt = 1'b0; dmem_req = 1'b0; branch = 1'b0;
    check("t5_halted", {31'b0, halted}, 32'h1);
    check("t5_iren", {31'b0, iREN}, 32'h0);
    check("t5_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      ihit = ~ihit; dhit = ihit;
      step();
      check("t5_frozen_pc", pc, 32'h48);
      check("t5_frozen_halted", {31'b0, halted}, 32'h1);
    end
    ihit = 1'b1; dhit = 1'b0;
    nRST = 1'b0;
    step();
    check("t5_rst_pc", pc, 32'h0);
    check("t5_rst_halted", {31'b0, halted}, 32'h0);
    check("t5_rst_iren", {31'b0, iREN}, 32'h0);
    nRST = 1'b1; #1;
    check("t5_fetch_iren", {31'b0, iREN}, 32'h1);

    // T6: PC wrap at top of address space
    step();
    branch = 1'b1; br_target = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    check("t6_pc_top", pc, 32'hFFFF_FFFC);
    step();
    check("t6_p4_wrap", pc_plus4, 32'h0);
    step();
    check("t6_addr_wrap", imemaddr, 32'h0);

    // T6: reset in MEM_WAIT discards the access
    step();
    branch = 1'b1; br_target = 32'h0000_0080;
    step();
    branch = 1'b0;
    imem_rdata = 32'h0000_A083;
    step();
    dmem_req = 1'b1; dhit = 1'b0;
    step();
    check("t6_mw_valid", {31'b0, instr_valid}, 32'h1);
    check("t6_mw_pc", pc, 32'h80);
    nRST = 1'b0;
    step();
    nRST = 1'b1; dmem_req = 1'b0; #1;
    check("t6_rst_pc", pc, 32'h0);
    check("t6_rst_load", imemload, 32'h0);
    check("t6_rst_valid", {31'b0, instr_valid}, 32'h0);
    check("t6_rst_iren", {31'b0, iREN}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
